hazard_unit: RTL
================

Name: hazard_unit

Overview:
- Pipeline hazard responder on the other end of the 5-stage ARM controller's hazard interface.
- Consumes the controller's pending-PC-write, branch, load and writeback indications together with decode-stage register addresses.
- Produces stall, flush and forwarding controls for the datapath.
- Owns the E/M/W register-address pipeline, so match logic operates on its own registered state.

Parameters:
- RW, 4, register address width (16 architectural registers).
- CNTW, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- RA1D  in  RW  decode-stage source register 1 (Rn)
- RA2D  in  RW  decode-stage source register 2 (Rm/Rd for STR)
- WA3D  in  RW  decode-stage destination register
- RegWriteM  in  1  memory-stage register write, condition-gated
- RegWriteW  in  1  writeback-stage register write
- MemtoRegE  in  1  execute-stage instruction is a load
- BranchTakenD  in  1  early-resolved branch taken in decode
- PCSrcW  in  1  PC write retiring in writeback
- PCWrPendingF  in  1  PC write in flight (D, E or M)
- StallCntClr  in  1  synchronous clear of the stall counter
- ForwardAE  out  2  SrcA select: 00 register file, 01 ResultW, 10 ALUOutM
- ForwardBE  out  2  SrcB select, same encoding
- StallF  out  1  hold PC register
- StallD  out  1  hold F/D pipeline register
- FlushD  out  1  clear F/D pipeline register
- FlushE  out  1  clear D/E pipeline register (also drives controller FlushE)
- StallCnt  out  CNTW  count of cycles with StallD=1, saturating

Behaviour:
- Internal state:
  - E stage: RA1E, RA2E, WA3E, ValidE.
  - M stage: WA3M.
  - W stage: WA3W.
- Reset (reset=0, asynchronous):
  - All internal registers and StallCnt clear to 0; ValidE clears to 0.
  - While reset is asserted, outputs are forced to ForwardAE=ForwardBE=00, StallF=StallD=0, FlushD=1, FlushE=1, regardless of inputs.
  - Reset release takes effect on the next rising clk; no partial state survives a mid-operation reset.
- Register pipeline, each rising clk:
  - If FlushE=1: ValidE<=0 and RA1E, RA2E, WA3E<=0.
  - Otherwise: RA1E<=RA1D, RA2E<=RA2D, WA3E<=WA3D, ValidE<=1.
  - WA3M<=WA3E and WA3W<=WA3M unconditionally. M and W never stall; gating is carried by RegWriteM/RegWriteW.
- Forwarding (combinational from registered state and inputs):
  - ForwardAE=10 if ValidE & RegWriteM & (RA1E==WA3M).
  - Else ForwardAE=01 if ValidE & RegWriteW & (RA1E==WA3W).
  - Else ForwardAE=00.
  - M has priority over W when both match. ForwardBE is identical using RA2E.
  - R15 is not special-cased: a match on register 15 forwards like any other.
- Load-use:
  - LDRstall = ValidE & MemtoRegE & ((RA1D==WA3E) | (RA2D==WA3E)).
  - Stall latency is exactly one cycle: the next cycle E holds a bubble (ValidE=0), so LDRstall deasserts.
- Control equations:
  - StallF = LDRstall | PCWrPendingF
  - StallD = LDRstall
  - FlushD = PCWrPendingF | PCSrcW | BranchTakenD
  - FlushE = LDRstall | BranchTakenD
- Simultaneous events:
  - LDRstall with BranchTakenD: both StallD=1 and FlushE=1; FlushD=1 also wins over StallD (the FlushD clear has priority in the F/D register).
  - PCSrcW with PCWrPendingF=0: only FlushD asserts; the PC is not stalled, so the new PC loads.
- Stall counter:
  - Rising clk: StallCntClr=1 -> 0.
  - Else if StallD=1 and StallCnt != all-ones -> +1.
  - At all-ones it holds (saturates, no wrap).

Test Plan:
- Reset: hold reset=0 with random inputs -> FlushD=FlushE=1, StallF=StallD=0, forwards 00, StallCnt=0. Release -> after one clk ValidE=1, normal operation.
- Back-to-back dependency: cycle0 WA3D=3; cycle1 RA1D=3; RegWriteM=1 in cycle2 -> ForwardAE=10 in cycle2. Third instruction with RA2D=3 and RegWriteW=1 -> ForwardBE=01. With both M and W matching r3 -> 10.
- Load-use: E holds load to r5 (MemtoRegE=1); D has RA2D=5 -> StallF=StallD=FlushE=1 for exactly one cycle; next cycle all 0 and StallCnt=1.
- Branch: BranchTakenD=1 -> FlushD=1, FlushE=1, StallF=0. Combined with LDRstall -> StallD=1, FlushD=1, FlushE=1.
- PC write: PCWrPendingF=1 for 3 cycles, then PCSrcW=1 with PCWrPendingF=0 -> StallF=1 and FlushD=1 for 3 cycles, then StallF=0 and FlushD=1 for 1 cycle.
- Counter saturation (CNTW=4): 20 consecutive load-use stalls -> StallCnt=15 and holds. StallCntClr=1 -> 0 next clk. Async reset mid-count -> 0 immediately.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the 5-stage ARM pipeline
// Inputs : clk, reset (async, active-low), decode addresses RA1D/RA2D/WA3D,
//          RegWriteM/RegWriteW, MemtoRegE, BranchTakenD, PCSrcW, PCWrPendingF,
//          StallCntClr
// Outputs: ForwardAE/ForwardBE (00 regfile, 01 ResultW, 10 ALUOutM), StallF,
//          StallD, FlushD, FlushE, StallCnt (saturating count of StallD cycles)
module hazard_unit #(
    parameter int RW   = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RW-1:0]   RA1D,
    input  logic [RW-1:0]   RA2D,
    input  logic [RW-1:0]   WA3D,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            MemtoRegE,
    input  logic            BranchTakenD,
    input  logic            PCSrcW,
    input  logic            PCWrPendingF,
    input  logic            StallCntClr,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic [CNTW-1:0] StallCnt
);
    logic [RW-1:0]   ra1e_q, ra2e_q, wa3e_q, wa3m_q, wa3w_q;
    logic            vale_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            ldr_stall;
    logic [1:0]      fa, fb;

    always_comb begin
        ldr_stall = vale_q & MemtoRegE & ((RA1D == wa3e_q) | (RA2D == wa3e_q));
        fa = (vale_q & RegWriteM & (ra1e_q == wa3m_q)) ? 2'b10 :
             (vale_q & RegWriteW & (ra1e_q == wa3w_q)) ? 2'b01 : 2'b00;
        fb = (vale_q & RegWriteM & (ra2e_q == wa3m_q)) ? 2'b10 :
             (vale_q & RegWriteW & (ra2e_q == wa3w_q)) ? 2'b01 : 2'b00;
        // while reset is held the pipeline is flushed, never stalled, never forwarded
        ForwardAE = reset ? fa : 2'b00;
        ForwardBE = reset ? fb : 2'b00;
        StallF    = reset & (ldr_stall | PCWrPendingF);
        StallD    = reset & ldr_stall;
        FlushD    = ~reset | PCWrPendingF | PCSrcW | BranchTakenD;
        FlushE    = ~reset | ldr_stall | BranchTakenD;
        cnt_d     = StallCntClr ? '0 :
                    (StallD && cnt_q != '1) ? cnt_q + CNTW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1e_q <= '0;
            ra2e_q <= '0;
            wa3e_q <= '0;
            vale_q <= 1'b0;
            wa3m_q <= '0;
            wa3w_q <= '0;
            cnt_q  <= '0;
        end else begin
            ra1e_q <= FlushE ? '0 : RA1D;
            ra2e_q <= FlushE ? '0 : RA2D;
            wa3e_q <= FlushE ? '0 : WA3D;
            vale_q <= ~FlushE;
            wa3m_q <= wa3e_q;
            wa3w_q <= wa3m_q;
            cnt_q  <= cnt_d;
        end
    end

    assign StallCnt = cnt_q;
endmodule
